// File: rtl/cv32e40p_if_stage_breakage_collector_ft.sv
// Breakage collector for the TMR-protected IF-stage submodules: saturating per-replica
// mismatch counters, sticky broken flags and an event FIFO towards the controller.
module cv32e40p_if_stage_breakage_collector_ft #(
   parameter int N_UNIT             = 6,
   parameter int N_REP              = 3,
   parameter int COUNT_BIT          = 8,
   parameter int INC_DEC_BIT        = 2,
   parameter int INCREMENT          = 1,
   parameter int DECREMENT          = 1,
   parameter int BREAKING_THRESHOLD = 3,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          err_valid_i,
   input  logic [N_UNIT*N_REP-1:0]       err_i,
   output logic [N_UNIT*N_REP-1:0]       broken_rep_o,
   output logic [N_UNIT-1:0]             broken_unit_o,
   output logic                          evt_valid_o,
   input  logic                          evt_ready_i,
   output logic [$clog2(N_UNIT)-1:0]     evt_unit_o,
   output logic [$clog2(N_REP)-1:0]      evt_rep_o,
   output logic [$clog2(FIFO_DEPTH):0]   evt_level_o
);

   localparam int N_TOT  = N_UNIT * N_REP;
   localparam int IDX_W  = $clog2(N_TOT);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int UNIT_W = $clog2(N_UNIT);
   localparam int REP_W  = $clog2(N_REP);

   localparam logic [INC_DEC_BIT-1:0] INC_C    = INC_DEC_BIT'(INCREMENT);
   localparam logic [INC_DEC_BIT-1:0] DEC_C    = INC_DEC_BIT'(DECREMENT);
   localparam logic [COUNT_BIT:0]     INC_X    = (COUNT_BIT+1)'(INC_C);
   localparam logic [COUNT_BIT:0]     DEC_X    = (COUNT_BIT+1)'(DEC_C);
   localparam logic [COUNT_BIT:0]     CNT_MAX  = (COUNT_BIT+1)'({COUNT_BIT{1'b1}});
   localparam logic [COUNT_BIT:0]     THRESH   = (COUNT_BIT+1)'(BREAKING_THRESHOLD);
   localparam logic [PTR_W:0]         FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

   logic [COUNT_BIT-1:0] cnt_q [N_TOT];
   logic [COUNT_BIT-1:0] cnt_d [N_TOT];
   logic [COUNT_BIT:0]   cnt_ext;
   logic [N_TOT-1:0]     broken_q;
   logic [N_TOT-1:0]     break_now;
   logic [N_TOT-1:0]     pending_q;
   logic [N_TOT-1:0]     pending_d;
   logic [IDX_W-1:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [PTR_W:0]       level_q;
   logic [IDX_W-1:0]     sel_idx;
   logic [IDX_W-1:0]     head_idx;
   logic                 sel_hit;
   logic                 push;
   logic                 pop;
   logic                 full;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_ext   = '0;
      break_now = '0;
      for (int i = 0; i < N_TOT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (err_valid_i && !broken_q[i]) begin
            // one extra bit catches both overflow and borrow before saturating
            if (err_i[i]) begin
               cnt_ext = {1'b0, cnt_q[i]} + INC_X;
               if (cnt_ext > CNT_MAX) cnt_ext = CNT_MAX;
            end else begin
               cnt_ext = {1'b0, cnt_q[i]} - DEC_X;
               if (cnt_ext[COUNT_BIT]) cnt_ext = '0;
            end
            cnt_d[i]     = cnt_ext[COUNT_BIT-1:0];
            break_now[i] = (cnt_ext >= THRESH);
         end
      end
   end

   // lowest-index pending replica wins the single push slot
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      for (int i = N_TOT - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_hit = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
   end

   assign full        = (level_q == FULL_LVL);
   assign evt_valid_o = (level_q != '0);
   assign pop         = evt_valid_o && evt_ready_i;
   assign push        = sel_hit && (!full || pop);

   always_comb begin
      pending_d = pending_q | break_now;
      if (push) pending_d[sel_idx] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_TOT; i++) cnt_q[i] <= '0;
         broken_q  <= '0;
         pending_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
      end else begin
         cnt_q     <= cnt_d;
         broken_q  <= broken_q | break_now;
         pending_q <= pending_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (pop && !push) level_q <= level_q - 1'b1;
      end
   end

   // NOTE: the storage array is not reset; the head fields are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= sel_idx;
   end

   assign head_idx     = fifo_mem[rd_ptr_q];
   assign evt_unit_o   = evt_valid_o ? UNIT_W'(int'(head_idx) / N_REP) : '0;
   assign evt_rep_o    = evt_valid_o ? REP_W'(int'(head_idx) % N_REP) : '0;
   assign evt_level_o  = level_q;
   assign broken_rep_o = broken_q;

   // a unit can still vote only while at most one of its replicas is broken
   always_comb begin
      broken_unit_o = '0;
      for (int u = 0; u < N_UNIT; u++) begin
         broken_unit_o[u] = ($countones(broken_q[u*N_REP +: N_REP]) >= 2);
      end
   end

endmodule

// File: tb/tb_cv32e40p_if_stage_breakage_collector_ft.sv
// Self-checking bench: queue-based reference model feeds an event scoreboard that a
// negedge monitor drains; directed test-plan scenarios followed by randomized episodes.
module tb_cv32e40p_if_stage_breakage_collector_ft;

   localparam int N_UNIT = 6;
   localparam int N_REP  = 3;
   localparam int N      = N_UNIT * N_REP;
   localparam int DEPTH  = 4;
   localparam int THRESH = 3;
   localparam int CMAX   = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          err_valid_i = 1'b0;
   logic          evt_ready_i = 1'b0;
   logic [N-1:0]  err_i = '0;
   logic [N-1:0]  broken_rep_o;
   logic [N_UNIT-1:0] broken_unit_o;
   logic          evt_valid_o;
   logic [2:0]    evt_unit_o;
   logic [1:0]    evt_rep_o;
   logic [2:0]    evt_level_o;

   int n_checks = 0;
   int n_err    = 0;
   int n_popped = 0;
   bit mon_en   = 1'b0;

   // reference model state
   int cnt_m [N];
   bit brk_m [N];
   bit pend_m [N];
   int fifo_m [$];
   int exp_q [$];
   int m_sel;
   bit m_pop;
   bit m_full;
   int mon_e;
   logic [4:0] pat2 = 5'b11011;

   cv32e40p_if_stage_breakage_collector_ft dut (
      .clk          (clk),
      .rst          (rst),
      .err_valid_i  (err_valid_i),
      .err_i        (err_i),
      .broken_rep_o (broken_rep_o),
      .broken_unit_o(broken_unit_o),
      .evt_valid_o  (evt_valid_o),
      .evt_ready_i  (evt_ready_i),
      .evt_unit_o   (evt_unit_o),
      .evt_rep_o    (evt_rep_o),
      .evt_level_o  (evt_level_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] brk_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = brk_m[i];
      return v;
   endfunction

   function automatic logic [N_UNIT-1:0] unit_vec();
      logic [N_UNIT-1:0] v;
      for (int u = 0; u < N_UNIT; u++) begin
         int c;
         c = 0;
         for (int r = 0; r < N_REP; r++) c += int'(brk_m[u*N_REP + r]);
         v[u] = (c >= 2);
      end
      return v;
   endfunction

   // behavioural model, advanced once per rising edge from the driven inputs
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            cnt_m[i]  = 0;
            brk_m[i]  = 1'b0;
            pend_m[i] = 1'b0;
         end
         fifo_m.delete();
         exp_q.delete();
      end else begin
         m_pop  = (fifo_m.size() != 0) && evt_ready_i;
         m_full = (fifo_m.size() == DEPTH);
         m_sel  = -1;
         for (int i = N - 1; i >= 0; i--) if (pend_m[i]) m_sel = i;
         if (m_pop) void'(fifo_m.pop_front());
         if (m_sel >= 0 && (!m_full || m_pop)) begin
            fifo_m.push_back(m_sel);
            exp_q.push_back(m_sel);
            pend_m[m_sel] = 1'b0;
         end
         if (err_valid_i) begin
            for (int i = 0; i < N; i++) begin
               if (!brk_m[i]) begin
                  if (err_i[i]) cnt_m[i] = (cnt_m[i] + 1 > CMAX) ? CMAX : cnt_m[i] + 1;
                  else          cnt_m[i] = (cnt_m[i] - 1 < 0) ? 0 : cnt_m[i] - 1;
                  if (cnt_m[i] >= THRESH) begin
                     brk_m[i]  = 1'b1;
                     pend_m[i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // monitor: compares state every cycle and consumes the scoreboard on each handshake
   always @(negedge clk) begin
      if (mon_en) begin
         check("evt_valid", evt_valid_o, fifo_m.size() != 0);
         check("evt_level", evt_level_o, fifo_m.size());
         check("broken_rep", broken_rep_o, brk_vec());
         check("broken_unit", broken_unit_o, unit_vec());
         if (evt_valid_o === 1'b1 && evt_ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL evt_unexpected: got unit %0d rep %0d expected no event at %0t",
                        evt_unit_o, evt_rep_o, $time);
            end else begin
               mon_e = exp_q.pop_front();
               n_popped++;
               check("evt_unit", evt_unit_o, mon_e / N_REP);
               check("evt_rep", evt_rep_o, mon_e % N_REP);
            end
         end
      end
   end

   task automatic step(input logic ev, input logic [N-1:0] e, input logic rdy);
      err_valid_i = ev;
      err_i       = e;
      evt_ready_i = rdy;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      int base;
      logic [N-1:0] hot;
      logic [N-1:0] e;

      do_reset();
      mon_en = 1'b1;
      check("rst_valid", evt_valid_o, 0);
      check("rst_level", evt_level_o, 0);
      check("rst_broken", broken_rep_o, 0);

      // single replica break: bit 4 = unit 1 rep 1
      for (int k = 0; k < 3; k++) step(1'b1, N'(1) << 4, 1'b0);
      check("t1_broken", broken_rep_o, 32'h10);
      check("t1_valid_early", evt_valid_o, 0);
      step(1'b0, '0, 1'b0);
      check("t1_valid", evt_valid_o, 1);
      check("t1_unit", evt_unit_o, 1);
      check("t1_rep", evt_rep_o, 1);
      check("t1_level", evt_level_o, 1);
      step(1'b0, '0, 1'b1);
      check("t1_popped", evt_valid_o, 0);

      // counter walk 1,2,1,2,3 on bit 0
      do_reset();
      base = n_popped;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, N'(pat2[k]), 1'b1);
         if (k == 3) check("t2_no_break", broken_rep_o, 0);
         if (k == 4) check("t2_break", broken_rep_o, 1);
      end
      for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
      check("t2_events", n_popped - base, 1);

      // whole unit 0 breaks, events queue in replica order
      do_reset();
      base = n_popped;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, N'(7), 1'b0);
         if (k == 1) check("t3_unit_ok", broken_unit_o, 0);
      end
      check("t3_broken", broken_rep_o, 7);
      check("t3_unit", broken_unit_o, 1);
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, '0, 1'b0);
         check("t3_level", evt_level_o, k);
      end
      step(1'b0, '0, 1'b0);
      check("t3_level_hold", evt_level_o, 3);
      check("t3_head_unit", evt_unit_o, 0);
      check("t3_head_rep", evt_rep_o, 0);
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1);
      check("t3_events", n_popped - base, 3);

      // six simultaneous breaks overflow the FIFO, then drain with push+pop overlap
      do_reset();
      base = n_popped;
      for (int k = 0; k < 3; k++) step(1'b1, N'(18'h1F8), 1'b0);
      for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b0);
      check("t4_level_full", evt_level_o, 4);
      check("t4_head_unit", evt_unit_o, 1);
      check("t4_head_rep", evt_rep_o, 0);
      step(1'b0, '0, 1'b1);
      check("t5_push_pop", evt_level_o, 4);
      step(1'b0, '0, 1'b1);
      check("t5_push_pop2", evt_level_o, 4);
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1);
      check("t4_drained", evt_level_o, 0);
      check("t4_events", n_popped - base, 6);

      // reset mid-operation discards queued events and counters
      do_reset();
      step(1'b1, N'(18'h0E00), 1'b0);
      step(1'b1, N'(18'h1E00), 1'b0);
      step(1'b1, N'(18'h1E00), 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0);
      check("t6_level_before", evt_level_o, 3);
      rst = 1'b1;
      step(1'b0, '0, 1'b0);
      rst = 1'b0;
      check("t6_broken", broken_rep_o, 0);
      check("t6_unit", broken_unit_o, 0);
      check("t6_valid", evt_valid_o, 0);
      check("t6_level", evt_level_o, 0);
      check("t6_evt_unit", evt_unit_o, 0);
      check("t6_evt_rep", evt_rep_o, 0);
      step(1'b1, N'(18'h1000), 1'b1);
      step(1'b1, N'(18'h1000), 1'b1);
      check("t6_cnt_cleared", broken_rep_o, 0);
      for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
      check("t6_no_stale", evt_valid_o, 0);

      // randomized episodes against the model
      for (int ep = 0; ep < 4; ep++) begin
         do_reset();
         hot = N'($urandom);
         for (int c = 0; c < 150; c++) begin
            e = '0;
            for (int b = 0; b < N; b++)
               e[b] = hot[b] ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) != 0, e, $urandom_range(0, 2) == 0);
            rst = 1'b0;
         end
         for (int c = 0; c < 30; c++) step(1'b0, '0, 1'b1);
         check("drain_empty", exp_q.size(), 0);
         check("drain_valid", evt_valid_o, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
